// File: rtl/nco_qw_pkg.sv
// Shared constants and the quarter-wave table generator for the nco_qw NCO.
// The LFSR constants are only used when NCO_DITHER_EN is defined.
package nco_pkg;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form: taps 16,14,13,11 map onto bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // round(amp * sin(pi/2 * k / m)) via a Taylor series, for table initialisation
    function automatic int lut_val(input int k, input int amp, input int m);
        real x;
        real term;
        real s;
        x    = 3.14159265358979 / 2.0 * real'(k) / real'(m);
        s    = x;
        term = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return $rtoi(real'(amp) * s + 0.5);
    endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Quarter-wave sine ROM, M+1 unsigned magnitude entries, with two registered
// read ports so sine and cosine magnitudes are fetched in the same cycle.
module nco_qw_rom
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-2:0] sin_addr,
    input  logic [LUT_AW-2:0] cos_addr,
    output logic [OUT_W-2:0]  sin_data,
    output logic [OUT_W-2:0]  cos_data
);

    localparam int M = 2 ** (LUT_AW - 2);
    localparam int A = 2 ** (OUT_W - 1) - 1;

    logic [OUT_W-2:0] rom [0:M];
    logic [OUT_W-2:0] sin_data_d, sin_data_q;
    logic [OUT_W-2:0] cos_data_d, cos_data_q;

    for (genvar k = 0; k <= M; k++) begin : g_rom
        localparam int V = lut_val(k, A, M);
        assign rom[k] = V[OUT_W-2:0];
    end

    always_comb begin
        sin_data_d = rom[sin_addr];
        cos_data_d = rom[cos_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sin_data_q <= '0;
            cos_data_q <= '0;
        end else begin
            sin_data_q <= sin_data_d;
            cos_data_q <= cos_data_d;
        end
    end

    assign sin_data = sin_data_q;
    assign cos_data = cos_data_q;

endmodule

// File: rtl/nco_qw.sv
// Pipelined quadrature NCO: phase accumulator, quadrant-folded quarter-wave ROM,
// registered signed outputs. Define NCO_DITHER_EN to add LFSR phase dither.
module nco_qw
    import nco_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [ACC_W-1:0] phase_inc,
    input  logic [ACC_W-1:0] phase_off,
    input  logic             load,
    input  logic [ACC_W-1:0] load_val,
    output logic [OUT_W-1:0] sine_out,
    output logic [OUT_W-1:0] cosine_out,
    output logic             out_valid
);

    localparam int M = 2 ** (LUT_AW - 2);
    localparam logic [LUT_AW-2:0] M_ADDR = M[LUT_AW-2:0];

    logic [ACC_W-1:0]  acc_d, acc_q;
    logic [LUT_AW-1:0] p_d, p_q;
    logic              v1_d, v1_q;
    logic [1:0]        q2_d, q2_q;
    logic              v2_d, v2_q;
    logic [OUT_W-1:0]  sine_d, sine_q;
    logic [OUT_W-1:0]  cosine_d, cosine_q;
    logic              valid_d, valid_q;

    logic [LUT_AW-3:0] idx;
    logic [LUT_AW-2:0] mir;
    logic [LUT_AW-2:0] sin_addr, cos_addr;
    logic [OUT_W-2:0]  sin_data, cos_data;
    logic [OUT_W-1:0]  sin_mag, cos_mag;
    logic              sin_neg, cos_neg;
    logic [ACC_W-1:0]  dither;

`ifdef NCO_DITHER_EN
    localparam int DW = (ACC_W - LUT_AW < 16) ? (ACC_W - LUT_AW) : 16;

    logic [15:0] lfsr_d, lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
        dither = {{(ACC_W - DW){1'b0}}, lfsr_q[DW-1:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dither = '0;
`endif

    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = load_val;
        end else if (en) begin
            acc_d = acc_q + phase_inc;
        end

        p_d  = LUT_AW'((acc_q + phase_off + dither) >> (ACC_W - LUT_AW));
        v1_d = en;

        // Odd quadrants read the table backwards, so the two ports swap roles.
        idx = p_q[LUT_AW-3:0];
        mir = M_ADDR - {1'b0, idx};
        q2_d = p_q[LUT_AW-1:LUT_AW-2];
        v2_d = v1_q;
        if (q2_d[0]) begin
            sin_addr = mir;
            cos_addr = {1'b0, idx};
        end else begin
            sin_addr = {1'b0, idx};
            cos_addr = mir;
        end

        case (q2_q)
            Q0:      begin sin_neg = 1'b0; cos_neg = 1'b0; end
            Q1:      begin sin_neg = 1'b0; cos_neg = 1'b1; end
            Q2:      begin sin_neg = 1'b1; cos_neg = 1'b1; end
            Q3:      begin sin_neg = 1'b1; cos_neg = 1'b0; end
            default: begin sin_neg = 1'b0; cos_neg = 1'b0; end
        endcase
        sin_mag  = {1'b0, sin_data};
        cos_mag  = {1'b0, cos_data};
        sine_d   = sin_neg ? ('0 - sin_mag) : sin_mag;
        cosine_d = cos_neg ? ('0 - cos_mag) : cos_mag;
        valid_d  = v2_q;
    end

    nco_qw_rom #(
        .LUT_AW(LUT_AW),
        .OUT_W (OUT_W)
    ) u_rom (
        .clk     (clk),
        .reset   (reset),
        .sin_addr(sin_addr),
        .cos_addr(cos_addr),
        .sin_data(sin_data),
        .cos_data(cos_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            p_q      <= '0;
            v1_q     <= 1'b0;
            q2_q     <= '0;
            v2_q     <= 1'b0;
            sine_q   <= '0;
            cosine_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            p_q      <= p_d;
            v1_q     <= v1_d;
            q2_q     <= q2_d;
            v2_q     <= v2_d;
            sine_q   <= sine_d;
            cosine_q <= cosine_d;
            valid_q  <= valid_d;
        end
    end

    assign sine_out   = sine_q;
    assign cosine_out = cosine_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_nco_qw.sv
// Scoreboard bench for nco_qw at default parameters (M=64, A=2047).
module tb_nco_qw;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [23:0] phase_inc;
    logic [23:0] phase_off;
    logic [23:0] load_val;
    logic [11:0] sine_out;
    logic [11:0] cosine_out;
    logic        out_valid;

    nco_qw dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .phase_inc (phase_inc),
        .phase_off (phase_off),
        .load      (load),
        .load_val  (load_val),
        .sine_out  (sine_out),
        .cosine_out(cosine_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] s;
        logic [11:0] c;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    int          lut[0:64];
    logic [23:0] model_acc;
    logic [15:0] model_lfsr;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Expected output for table phase p, folded by quadrant
    function automatic exp_t predict(input logic [7:0] p, input logic v);
        exp_t e;
        int   idx;
        int   s;
        int   c;
        idx = int'(p[5:0]);
        case (p[7:6])
            2'd0:    begin s =  lut[idx];      c =  lut[64 - idx]; end
            2'd1:    begin s =  lut[64 - idx]; c = -lut[idx];      end
            2'd2:    begin s = -lut[idx];      c = -lut[64 - idx]; end
            default: begin s = -lut[64 - idx]; c =  lut[idx];      end
        endcase
        e.s = s[11:0];
        e.c = c[11:0];
        e.v = v;
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(expv), expv);
        end
    endtask

    // Two reset-state samples are already in the pipe after release
    task automatic resetScoreboard();
        exp_t e;
        sb.delete();
        e.s = '0;
        e.c = '0;
        e.v = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        model_acc  = '0;
        model_lfsr = 16'hACE1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("[TB] FAIL scoreboard_empty: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        checkValue("out_valid", {11'b0, out_valid}, {11'b0, e.v});
        if (e.v) begin
            checkValue("sine_out", sine_out, e.s);
            checkValue("cosine_out", cosine_out, e.c);
        end
        n_checks++;
        assert (sine_out !== 12'h800 && cosine_out !== 12'h800)
        else begin
            n_fail++;
            $error("[TB] FAIL no_neg_full_scale: observed sine %0d cosine %0d expected neither -2048",
                   $signed(sine_out), $signed(cosine_out));
        end
    endtask

    // Called on a falling edge; drives one cycle and checks the output after the edge
    task automatic applyStimulus(input logic en_i, input logic load_i, input logic [23:0] inc_i,
                                 input logic [23:0] off_i, input logic [23:0] lv_i);
        logic [23:0] sum;
        en        = en_i;
        load      = load_i;
        phase_inc = inc_i;
        phase_off = off_i;
        load_val  = lv_i;
        sum = model_acc + off_i;
`ifdef NCO_DITHER_EN
        sum = sum + {8'b0, model_lfsr};
        if (en_i) model_lfsr = {model_lfsr[0] ^ model_lfsr[2] ^ model_lfsr[3] ^ model_lfsr[5],
                                model_lfsr[15:1]};
`endif
        sb.push_back(predict(sum[23:16], en_i));
        if (load_i) model_acc = lv_i;
        else if (en_i) model_acc = model_acc + inc_i;
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k <= 64; k++) begin
            lut[k] = $rtoi(2047.0 * $sin(3.14159265358979 / 2.0 * real'(k) / 64.0) + 0.5);
        end

        reset     = 1'b0;
        en        = 1'b1;
        load      = 1'b0;
        phase_inc = 24'h010000;
        phase_off = '0;
        load_val  = '0;
        repeat (3) @(negedge clk);
        #1;
        checkValue("reset_sine", sine_out, 12'd0);
        checkValue("reset_cosine", cosine_out, 12'd0);
        checkValue("reset_valid", {11'b0, out_valid}, 12'd0);
        @(negedge clk);
        reset = 1'b1;
        resetScoreboard();

        $display("[TB] sweep");
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 1'b0, 24'h010000, 24'h0, 24'h0);

        $display("[TB] enable gaps");
        applyStimulus(1'b1, 1'b0, 24'h010000, 24'h0, 24'h0);
        applyStimulus(1'b0, 1'b0, 24'h010000, 24'h0, 24'h0);
        applyStimulus(1'b1, 1'b0, 24'h010000, 24'h0, 24'h0);
        applyStimulus(1'b0, 1'b0, 24'h010000, 24'h0, 24'h0);
        applyStimulus(1'b0, 1'b0, 24'h010000, 24'h0, 24'h0);

        $display("[TB] load priority");
        applyStimulus(1'b1, 1'b0, 24'h010000, 24'h0, 24'h0);
        applyStimulus(1'b1, 1'b1, 24'h010000, 24'h0, 24'h800000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 24'h0, 24'h0, 24'h0);

        $display("[TB] static offset");
        applyStimulus(1'b1, 1'b1, 24'h0, 24'h400000, 24'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 24'h0, 24'h400000, 24'h0);

        $display("[TB] random control words");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                          24'($urandom), 24'($urandom), 24'($urandom));
        end

        $display("[TB] mid-run reset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 24'h010000, 24'h0, 24'h0);
        #2;
        reset = 1'b0;
        #1;
        checkValue("midreset_sine", sine_out, 12'd0);
        checkValue("midreset_cosine", cosine_out, 12'd0);
        checkValue("midreset_valid", {11'b0, out_valid}, 12'd0);
        @(negedge clk);
        reset = 1'b1;
        resetScoreboard();
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b0, 24'h010000, 24'h0, 24'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_qw.md
Name: nco_qw

Overview:
Parametrised, pipelined quadrature NCO; successor to the 8-bit full-table NCO.
- Wide phase accumulator with synchronous phase load and a static phase offset.
- Quarter-wave sine ROM with quadrant folding; signed sine/cosine outputs with a valid strobe.
- Feeds mixers/DDS paths in the DSP datapath.

Parameters:
ACC_W, 24, phase accumulator width (bits); must exceed LUT_AW
LUT_AW, 8, phase bits used for lookup (full cycle = 2^LUT_AW points, must be >= 4); quarter ROM has N = 2^(LUT_AW-2) + 1 entries
OUT_W, 12, signed output width; amplitude A = 2^(OUT_W-1) - 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  accumulator advance / sample strobe
phase_inc  input  ACC_W  unsigned frequency control word
phase_off  input  ACC_W  phase offset added after the accumulator
load  input  1  synchronous accumulator load
load_val  input  ACC_W  value loaded into the accumulator
sine_out  output  OUT_W  signed two's-complement sine
cosine_out  output  OUT_W  signed two's-complement cosine
out_valid  output  1  outputs carry a sample launched with en=1

Behaviour:
- Reset (reset=0, asynchronous): acc, all pipeline registers, sine_out, cosine_out and out_valid go to 0. This applies immediately, including mid-operation. Release is synchronous to clk.
- Accumulator update, in priority order:
  - load=1: acc <= load_val (load beats en).
  - else en=1: acc <= acc + phase_inc, mod 2^ACC_W; wrap is silent.
  - else: acc holds.
- S1 register: p <= top LUT_AW bits of (acc + phase_off) mod 2^ACC_W; v1 <= en.
- S2 register:
  - q <= p[LUT_AW-1:LUT_AW-2]; idx <= p[LUT_AW-3:0]; v2 <= v1.
  - Mirror address N-1-idx (= 2^(LUT_AW-2) - idx) is computed here.
- S3 register (outputs), where M = N-1 and L[k] = round(A*sin(pi/2*k/M)), k = 0..M:
  - q=0: sin = L[idx], cos = L[M-idx]
  - q=1: sin = L[M-idx], cos = -L[idx]
  - q=2: sin = -L[idx], cos = -L[M-idx]
  - q=3: sin = -L[M-idx], cos = L[idx]
  - out_valid <= v2.
- Latency: the acc value present after edge k appears on the outputs after edge k+3.
- The pipeline advances every cycle regardless of en; out_valid marks en-qualified samples.
- Output range is symmetric, -A..+A; -2^(OUT_W-1) never occurs. Negation is in OUT_W bits without overflow.
- Loading during a run: the new phase reaches the outputs 3 cycles after the load edge; samples already in flight complete unchanged.
- phase_inc=0 with en=1: constant output, out_valid=1.
- phase_inc / phase_off may change any cycle; each takes effect on the next edge.

Optional Feature:
Macro NCO_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances on cycles with en=1.
  - Its low D = min(16, ACC_W-LUT_AW) bits are added, zero-extended, to (acc + phase_off) before S1 truncation, mod 2^ACC_W.
  - Latency is unchanged.
- Undefined: plain truncation, no LFSR logic.

Decomposition:
- Package nco_pkg contains:
  - quadrant encoding constants (Q0..Q3);
  - the LFSR seed and tap constants;
  - a constant function computing L[k] from A and M, used for ROM initialisation.
- Sub-module nco_qw_rom: quarter-wave ROM, M+1 entries of OUT_W-1 bits, two registered read ports (sin and cos addresses), one read per port per cycle.
- Top level holds the accumulator, S1/S2, sign application and the valid pipe.

Test Plan (defaults, M=64, A=2047, macro undefined):
- Reset: hold reset=0 with en=1, then release → outputs 0/0, out_valid=0. First en cycle → 3 edges later out_valid=1, sine=0, cosine=2047.
- Sweep: phase_inc=0x010000, en=1 → one p step per cycle; p=0,64,128,192 give (sin,cos) = (0,2047), (2047,0), (0,-2047), (-2047,0). Period 256 samples; accumulator wraps to 0 after 256 steps.
- Offset: phase_off=0x400000, phase_inc=0 → sine=2047, cosine=0 constant. Output is never -2048 anywhere in the sweep.
- Load priority: load=1, en=1, load_val=0x800000 on one edge → acc=0x800000, not incremented; 3 cycles later sine=0, cosine=-2047. The 2 in-flight samples are unchanged.
- Enable gaps: en toggles 1,0,1 → acc advances twice; out_valid pattern is 1,0,1, delayed 3 cycles.
- Mid-run reset: assert reset=0 asynchronously between edges → outputs and out_valid drop to 0 before the next edge. After release the sweep restarts from phase 0.
